local_port_ingress_buffer: RTL and testbench

//  Sits directly downstream of a PE injector: receives injector packets over the Req/Gnt/Full

---
 rtl/local_port_ingress_buffer_pkg.sv | 24 ++
 rtl/local_port_ingress_buffer_fifo.sv | 56 +++++
 rtl/local_port_ingress_buffer.sv | 109 ++++++++++
 tb/tb_local_port_ingress_buffer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/local_port_ingress_buffer_pkg.sv
// Shared types for the local-port ingress buffer: packet layout and egress state encoding.
package local_port_ingress_buffer_pkg;

    localparam int DATA_W   = 32;
    localparam int DIM_W    = 4;
    localparam int PKT_ID_W = 10;
    localparam int MOD_ID_W = 6;

    // Packet layout, MSB first. The buffer carries packets opaquely; this is for reference/debug.
    typedef struct packed {
        logic [DIM_W-1:0]    x_dst;
        logic [DIM_W-1:0]    y_dst;
        logic [DIM_W-1:0]    x_src;
        logic [DIM_W-1:0]    y_src;
        logic [PKT_ID_W-1:0] packet_id;
        logic [MOD_ID_W-1:0] module_id;
    } noc_pkt_t;

    typedef enum logic {
        E_IDLE = 1'b0,
        E_WAIT = 1'b1
    } egress_state_t;

endpackage

// File: rtl/local_port_ingress_buffer_fifo.sv
// Small synchronous FIFO: storage, wrapping pointers and an occupancy count of 0..DEPTH.
module local_port_ingress_buffer_fifo #(
    parameter int DW     = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DW-1:0]     i_wdata,
    output logic [DW-1:0]     o_rdata,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_empty
);

    logic [DW-1:0]     r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;

    // Storage write; contents need no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop in one cycle leave the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == (ADDR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/local_port_ingress_buffer.sv
// Ingress buffer between a PE injector and the router local input.
// Accepts packets with a one-cycle grant pulse, queues them, and re-requests toward the router.
module local_port_ingress_buffer
    import local_port_ingress_buffer_pkg::*;
#(
    parameter int dataWidth = DATA_W,
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ReqUpStr,
    input  logic [dataWidth-1:0] PacketIn,
    output logic                 GntUpStr,
    output logic                 UpStrFull,
    output logic                 ReqDnStr,
    output logic [dataWidth-1:0] PacketOut,
    input  logic                 GntDnStr,
    input  logic                 DnStrFull,
    output logic [15:0]          PktInCnt,
    output logic [15:0]          PktOutCnt
);

    logic                 r_gnt_up;
    logic                 r_req_dn;
    logic [dataWidth-1:0] r_pkt_out;
    logic [15:0]          r_in_cnt;
    logic [15:0]          r_out_cnt;
    egress_state_t        r_state;

    logic                 w_push;
    logic                 w_pop;
    logic [dataWidth-1:0] w_head;
    logic [ADDR_W:0]      w_count;
    logic                 w_full;
    logic                 w_empty;

    // The grant term stops a second write while the injector still holds Req after its grant.
    assign w_push = ReqUpStr & ~r_gnt_up & ~w_full;
    assign w_pop  = (r_state == E_WAIT) & GntDnStr;

    local_port_ingress_buffer_fifo #(
        .DW     (dataWidth),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (PacketIn),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Ingress grant pulse and accepted-packet counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt_up <= 1'b0;
            r_in_cnt <= '0;
        end else begin
            r_gnt_up <= w_push;
            if (w_push) begin
                r_in_cnt <= r_in_cnt + 16'd1;
            end
        end
    end

    // Egress FSM: latch the head and request; once requested, wait for the grant regardless of DnStrFull.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= E_IDLE;
            r_req_dn  <= 1'b0;
            r_pkt_out <= '0;
            r_out_cnt <= '0;
        end else begin
            case (r_state)
                E_IDLE: begin
                    if (!w_empty && !DnStrFull) begin
                        r_pkt_out <= w_head;
                        r_req_dn  <= 1'b1;
                        r_state   <= E_WAIT;
                    end
                end
                E_WAIT: begin
                    if (GntDnStr) begin
                        r_req_dn  <= 1'b0;
                        r_out_cnt <= r_out_cnt + 16'd1;
                        r_state   <= E_IDLE;
                    end
                end
                default: begin
                    r_req_dn <= 1'b0;
                    r_state  <= E_IDLE;
                end
            endcase
        end
    end

    assign GntUpStr  = r_gnt_up;
    assign UpStrFull = (w_count == (ADDR_W+1)'(DEPTH));
    assign ReqDnStr  = r_req_dn;
    assign PacketOut = r_pkt_out;
    assign PktInCnt  = r_in_cnt;
    assign PktOutCnt = r_out_cnt;

endmodule

// File: tb/tb_local_port_ingress_buffer.sv
// Bench for the local-port ingress buffer: directed scenarios plus a randomized run,
// all checked by a cycle-level reference model and a packet scoreboard.
module tb_local_port_ingress_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ReqUpStr;
    logic [31:0] PacketIn;
    logic        GntUpStr;
    logic        UpStrFull;
    logic        ReqDnStr;
    logic [31:0] PacketOut;
    logic        GntDnStr;
    logic        DnStrFull;
    logic [15:0] PktInCnt;
    logic [15:0] PktOutCnt;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int rtr_mode = 0;   // 0 never grant, 1 random, 2 always, 3 grant once
    bit inj_done;

    local_port_ingress_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .ReqUpStr  (ReqUpStr),
        .PacketIn  (PacketIn),
        .GntUpStr  (GntUpStr),
        .UpStrFull (UpStrFull),
        .ReqDnStr  (ReqDnStr),
        .PacketOut (PacketOut),
        .GntDnStr  (GntDnStr),
        .DnStrFull (DnStrFull),
        .PktInCnt  (PktInCnt),
        .PktOutCnt (PktOutCnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting (cycle %0d)", nm, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Injector: present a packet, hold Req until the grant is seen, optionally one cycle longer.
    task automatic send(input logic [31:0] pkt, input bit lazy, input int limit, output int gcyc);
        bit got;
        got = 0;
        gcyc = 0;
        PacketIn = pkt;
        ReqUpStr = 1'b1;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (GntUpStr === 1'b1) begin
                got = 1;
                gcyc = cyc;
                break;
            end
        end
        if (!got) bound_fail("send_grant");
        if (lazy) tick();
        ReqUpStr = 1'b0;
        PacketIn = $urandom;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic wait_out(input int target, input int limit);
        bit ok;
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            if (PktOutCnt == 16'(target)) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) bound_fail("wait_out");
    endtask

    // Router model: grants the local-port request according to rtr_mode.
    initial begin
        bit used;
        used = 0;
        GntDnStr = 1'b0;
        forever begin
            tick();
            case (rtr_mode)
                1: GntDnStr = ReqDnStr && ($urandom_range(0, 2) == 0);
                2: GntDnStr = ReqDnStr;
                3: begin
                    GntDnStr = ReqDnStr && !used;
                    if (ReqDnStr) used = 1;
                end
                default: GntDnStr = 1'b0;
            endcase
            if (rtr_mode != 3) used = 0;
        end
    end

    // Monitor: predicts each edge's outcome from the previous cycle's inputs and the model occupancy,
    // keeps the expected packet order in a queue and checks what the DUT presents.
    initial begin
        logic [31:0] sb[$];
        int          occ, m_in, m_out;
        bit          p_reset, p_req_up, p_gnt_up, p_req_dn, p_gnt_dn, p_dn_full;
        logic [31:0] p_pkt_in, p_pkt_out;
        bit          e_gnt, popped, e_req;
        logic [31:0] exp_pkt;
        occ = 0; m_in = 0; m_out = 0;
        p_reset = 1; p_req_up = 0; p_gnt_up = 0; p_req_dn = 0; p_gnt_dn = 0; p_dn_full = 0;
        p_pkt_in = '0; p_pkt_out = '0;
        forever begin
            @(negedge clk);
            if (p_reset) begin
                sb.delete();
                occ = 0; m_in = 0; m_out = 0;
                chk("rst_gnt_up", 32'(GntUpStr), 0);
                chk("rst_req_dn", 32'(ReqDnStr), 0);
                chk("rst_pkt_out", PacketOut, 0);
                chk("rst_full", 32'(UpStrFull), 0);
                chk("rst_in_cnt", 32'(PktInCnt), 0);
                chk("rst_out_cnt", 32'(PktOutCnt), 0);
            end else begin
                e_gnt  = p_req_up && !p_gnt_up && (occ < DEPTH);
                popped = p_req_dn && p_gnt_dn;
                e_req  = p_req_dn ? !p_gnt_dn : ((occ != 0) && !p_dn_full);
                chk("gnt_up", 32'(GntUpStr), 32'(e_gnt));
                if (popped) begin
                    if (sb.size() == 0) begin
                        bound_fail("pop_with_empty_model");
                    end else begin
                        exp_pkt = sb.pop_front();
                        chk("forwarded_pkt", p_pkt_out, exp_pkt);
                    end
                    m_out++;
                end
                if (e_gnt) begin
                    sb.push_back(p_pkt_in);
                    m_in++;
                end
                occ = occ + int'(e_gnt) - int'(popped);
                chk("req_dn", 32'(ReqDnStr), 32'(e_req));
                chk("up_full", 32'(UpStrFull), 32'(occ == DEPTH));
                chk("in_cnt", 32'(PktInCnt), 32'(m_in[15:0]));
                chk("out_cnt", 32'(PktOutCnt), 32'(m_out[15:0]));
                if (ReqDnStr && !p_req_dn && e_req && sb.size() > 0)
                    chk("head_pkt", PacketOut, sb[0]);
                if (ReqDnStr && p_req_dn)
                    chk("hold_pkt", PacketOut, p_pkt_out);
            end
            p_reset   = reset;
            p_req_up  = ReqUpStr;
            p_gnt_up  = GntUpStr;
            p_req_dn  = ReqDnStr;
            p_gnt_dn  = GntDnStr;
            p_dn_full = DnStrFull;
            p_pkt_in  = PacketIn;
            p_pkt_out = PacketOut;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, g1;
        logic [31:0] first;
        bit ok;

        reset = 1'b1; ReqUpStr = 1'b1; PacketIn = 32'h1234_5678; DnStrFull = 1'b0;

        // Reset held with a pending request.
        repeat (3) tick();
        chk("t1_gnt_up", 32'(GntUpStr), 0);
        chk("t1_req_dn", 32'(ReqDnStr), 0);
        chk("t1_pkt_out", PacketOut, 0);
        chk("t1_cnts", {PktInCnt, PktOutCnt}, 0);
        ReqUpStr = 1'b0;
        reset = 1'b0;
        tick();

        // Single packet, router grants one cycle after the request.
        rtr_mode = 2;
        send(32'hA200_0045, 1'b0, 20, g);
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            if (ReqDnStr === 1'b1) begin ok = 1; break; end
            tick();
        end
        if (!ok) bound_fail("t2_req_dn");
        else begin
            chk("t2_latency", 32'(cyc - g), 1);
            chk("t2_pkt_out", PacketOut, 32'hA200_0045);
        end
        wait_out(1, 10);
        chk("t2_in_cnt", 32'(PktInCnt), 1);
        chk("t2_out_cnt", 32'(PktOutCnt), 1);

        // Lazy injector: Req held one cycle past the grant must not produce a second write.
        do_reset(1);
        rtr_mode = 0;
        send(32'h1357_9BDF, 1'b1, 20, g);
        repeat (3) tick();
        chk("t3_in_cnt", 32'(PktInCnt), 1);
        chk("t3_full", 32'(UpStrFull), 0);

        // Fill the FIFO, fifth request stalls until one packet leaves.
        do_reset(1);
        rtr_mode = 0;
        for (int i = 0; i < DEPTH; i++) send(32'hC000_0000 + 32'(i), 1'b0, 20, g);
        tick();
        chk("t4_full", 32'(UpStrFull), 1);
        fork
            send(32'hC000_0004, 1'b0, 40, g1);
            begin
                repeat (4) tick();
                chk("t4_no_grant", 32'(PktInCnt), 4);
                rtr_mode = 3;
            end
        join
        chk("t4_in_cnt", 32'(PktInCnt), 5);
        rtr_mode = 2;
        wait_out(5, 40);

        // Downstream full blocks the request; releasing it presents the oldest packet.
        do_reset(1);
        rtr_mode = 2;
        DnStrFull = 1'b1;
        first = 32'hD5D5_0001;
        send(first, 1'b0, 20, g);
        send(32'hD5D5_0002, 1'b0, 20, g);
        repeat (3) tick();
        chk("t5_no_req", 32'(ReqDnStr), 0);
        DnStrFull = 1'b0;
        tick();
        chk("t5_req", 32'(ReqDnStr), 1);
        chk("t5_head", PacketOut, first);
        wait_out(2, 20);

        // Reset pulse while a request is outstanding discards everything.
        do_reset(1);
        rtr_mode = 0;
        for (int i = 0; i < 3; i++) send(32'hE000_0000 + 32'(i), 1'b0, 20, g);
        tick();
        chk("t6_req_before", 32'(ReqDnStr), 1);
        do_reset(1);
        chk("t6_req_after", 32'(ReqDnStr), 0);
        repeat (5) tick();
        chk("t6_still_idle", 32'(ReqDnStr), 0);
        chk("t6_out_cnt", 32'(PktOutCnt), 0);

        // Randomized traffic with random router grants and downstream back-pressure.
        rtr_mode = 1;
        inj_done = 0;
        fork
            begin
                int gg;
                for (int n = 0; n < 300; n++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    send($urandom, 1'($urandom_range(0, 3) == 0), 200, gg);
                end
                inj_done = 1;
            end
            begin
                while (!inj_done) begin
                    DnStrFull = ($urandom_range(0, 5) == 0);
                    tick();
                end
                DnStrFull = 1'b0;
            end
        join
        rtr_mode = 2;
        repeat (30) tick();
        chk("rand_drained", 32'(PktOutCnt), 32'(PktInCnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
